// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension multiply/divide unit: radix-2 shift-add multiply,
// restoring divide, sign fix-up cycle and single-cycle divide corner-case early-out.
module muldiv_unit #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             busy
);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH-1);

  typedef enum logic [1:0] {IDLE, BUSY, FIXUP, DONE} state_t;

  state_t           state_reg, state_next;
  logic [2:0]       op_reg, op_next;
  logic             sa_reg, sa_next;
  logic             sb_reg, sb_next;
  logic [WIDTH-1:0] hi_reg, hi_next;
  logic [WIDTH-1:0] lo_reg, lo_next;
  logic [WIDTH-1:0] den_reg, den_next;
  logic [WIDTH-1:0] out_reg, out_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  // Operand sign handling at accept time
  logic             sign_a_en, sign_b_en;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             div_zero, div_ovf;

  assign sign_a_en = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  assign sign_b_en = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  assign a_neg     = sign_a_en & a[WIDTH-1];
  assign b_neg     = sign_b_en & b[WIDTH-1];
  assign a_mag     = a_neg ? -a : a;
  assign b_mag     = b_neg ? -b : b;
  assign div_zero  = op[2] && (b == '0);
  assign div_ovf   = ((op == OP_DIV) || (op == OP_REM)) && (a == MOST_NEG) && (b == '1);

  // One multiply step: conditional add of the multiplicand, then shift {hi,lo} right
  logic [WIDTH:0] mul_sum;
  assign mul_sum = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, den_reg} : {(WIDTH+1){1'b0}});

  // One restoring divide step: shift the next dividend bit into the partial remainder
  logic [WIDTH:0]   div_shift;
  logic             div_ok;
  logic [WIDTH-1:0] div_diff;
  assign div_shift = {hi_reg, lo_reg[WIDTH-1]};
  assign div_ok    = div_shift >= {1'b0, den_reg};
  assign div_diff  = div_shift[WIDTH-1:0] - den_reg;

  // Sign fix-up of the raw magnitudes
  logic [2*WIDTH-1:0] prod_raw, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic [WIDTH-1:0]   result;

  assign prod_raw = {hi_reg, lo_reg};
  assign prod_fix = (sa_reg ^ sb_reg) ? -prod_raw : prod_raw;
  assign quo_fix  = (sa_reg ^ sb_reg) ? -lo_reg : lo_reg;
  assign rem_fix  = sa_reg ? -hi_reg : hi_reg;

  always_comb begin
    result = '0;
    case (op_reg)
      OP_MUL:                       result = prod_fix[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: result = prod_fix[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:              result = quo_fix;
      OP_REM, OP_REMU:              result = rem_fix;
      default:                      result = '0;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    op_next    = op_reg;
    sa_next    = sa_reg;
    sb_next    = sb_reg;
    hi_next    = hi_reg;
    lo_next    = lo_reg;
    den_next   = den_reg;
    out_next   = out_reg;
    cnt_next   = cnt_reg;

    case (state_reg)
      IDLE: begin
        if (in_valid && !flush) begin
          op_next  = op;
          sa_next  = a_neg;
          sb_next  = b_neg;
          cnt_next = '0;
          if (div_zero) begin
            out_next   = op[1] ? a : '1;
            state_next = DONE;
          end else if (div_ovf) begin
            out_next   = op[1] ? '0 : a;
            state_next = DONE;
          end else begin
            hi_next    = '0;
            lo_next    = a_mag;
            den_next   = b_mag;
            state_next = BUSY;
          end
        end
      end
      BUSY: begin
        if (op_reg[2]) begin
          hi_next = div_ok ? div_diff : div_shift[WIDTH-1:0];
          lo_next = {lo_reg[WIDTH-2:0], div_ok};
        end else begin
          hi_next = mul_sum[WIDTH:1];
          lo_next = {mul_sum[0], lo_reg[WIDTH-1:1]};
        end
        if (cnt_reg == LAST_CNT) begin
          cnt_next   = '0;
          state_next = FIXUP;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      FIXUP: begin
        out_next   = result;
        state_next = DONE;
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // A redirect kills whatever is in flight; in IDLE the accept above is already blocked
    if (flush) state_next = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      op_reg    <= '0;
      sa_reg    <= 1'b0;
      sb_reg    <= 1'b0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      den_reg   <= '0;
      out_reg   <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      op_reg    <= op_next;
      sa_reg    <= sa_next;
      sb_reg    <= sb_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
      den_reg   <= den_next;
      out_reg   <= out_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg != IDLE);
  assign out       = out_reg;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised, multi-cycle multiply/divide unit implementing the RISC-V M-extension operations, generalised to WIDTH bits.
- Sits beside the single-cycle ALU in the execute stage and is selected by the decoder for funct7 = 0000001.
- Accepts one operation at a time over a valid/ready handshake and returns one result over a valid/ready handshake.
- Uses iterative radix-2 shift-add for multiply and restoring shift-subtract for divide, with sign fix-up and RISC-V corner-case early-out.

Parameters:
- WIDTH, 32, operand and result width in bits; must be at least 4.
- CNT_W, $clog2(WIDTH), width of the iteration counter; derived, not overridden.

Ports:
- clk, input, 1, single clock; all state updates on rising edge.
- rst, input, 1, reset; asynchronous, active-high.
- flush, input, 1, synchronous kill of the in-flight operation, used on pipeline redirect.
- in_valid, input, 1, an operation is presented.
- in_ready, output, 1, unit can accept an operation.
- op, input, 3, funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- a, input, WIDTH, rs1 operand.
- b, input, WIDTH, rs2 operand.
- out_valid, output, 1, result is valid.
- out_ready, input, 1, consumer accepts the result.
- out, output, WIDTH, result.
- busy, output, 1, high in any state other than IDLE.

Behaviour:
- Reset, asserted at any time including mid-operation: state goes to IDLE, in_ready=1, out_valid=0, out=0, busy=0, and the counter and datapath registers clear.
- States: IDLE, BUSY, FIXUP, DONE.
- in_ready=1 only in IDLE. The unit accepts an operation on an edge where in_valid & in_ready is high; op, a and b are captured on that edge.
- IDLE to BUSY on accept.
  - Operand signs are recorded per op: MULH signs both; MULHSU signs a only; DIV/REM sign both; MUL, MULHU, DIVU and REMU treat both as unsigned magnitudes.
  - Magnitudes (absolute values) are loaded into the datapath.
- BUSY performs one iteration per cycle for exactly WIDTH cycles, with the counter running 0 to WIDTH-1, then moves to FIXUP.
- FIXUP, one cycle:
  - Multiply: if the signs differ, negate the full 2*WIDTH-bit product.
  - Divide: negate the quotient if the signs differ; the remainder takes the sign of the dividend.
  - Then select the result: MUL takes the low WIDTH bits; MULH, MULHSU and MULHU take the high WIDTH bits; DIV/DIVU take the quotient; REM/REMU take the remainder.
  - Moves to DONE.
- DONE: out_valid=1 and out is held stable until out_valid & out_ready; then the state returns to IDLE and out_valid drops on that edge.
- Latency: with accept on edge E, out_valid rises after edge E+WIDTH+1, so WIDTH+1 cycles.
- Early-out paths go IDLE to DONE directly on the accept edge, so out_valid is high after edge E (1 cycle):
  - Divide by zero (b=0, ops 1xx): DIV/DIVU give all ones; REM/REMU give a.
  - Signed overflow (DIV/REM with a = most negative, b = all ones): DIV gives a; REM gives 0.
- flush high on an edge in BUSY, FIXUP or DONE: return to IDLE and drop out_valid; no result is produced.
- flush in IDLE has no effect; a simultaneous in_valid is ignored, so nothing is accepted.
- rst has priority over flush, and flush has priority over accept.
- All arithmetic is modulo 2^WIDTH on the output; no exceptions or flags are raised.

Test Plan:
- Reset mid-BUSY (DIVU 100/7, rst pulsed asynchronously between edges on cycle 5) -> out_valid=0, out=0 and in_ready=1 immediately; a following MUL 3*4 gives 12.
- MUL a=0xFFFFFFFF, b=2 -> out=0xFFFFFFFE, out_valid exactly 33 cycles after accept; MULHU with the same operands gives 0x00000001; MULH gives 0xFFFFFFFF; MULHSU gives 0xFFFFFFFF.
- DIV -7/2 -> out=0xFFFFFFFD (-3); REM -7/2 -> 0xFFFFFFFF (-1); DIVU 0xFFFFFFF9/2 -> 0x7FFFFFFC; REMU -> 1.
- Divide by zero DIV 5/0 -> out=0xFFFFFFFF after 1 cycle; REMU 5/0 gives 5. Overflow DIV 0x80000000/0xFFFFFFFF -> out=0x80000000; REM gives 0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out stays stable and in_ready stays 0; out_ready=1 -> returns to IDLE on the next edge.
- Flush at BUSY cycle 10 with in_valid also high -> no out_valid; in_ready=1 next cycle. Regression with WIDTH=8: MUL 0x80*0x80 gives MULHU=0x40, MULH=0x40, DIV 0x80/0xFF gives 0x80.
